// File: rtl/mac_seq_ctrl_if.sv
// Scheduler/buffer/MAC-side bundle of the MAC job sequencer.
// slave: sequencer side; master: scheduler, buffers and MAC side.
interface mac_seq_ctrl_if #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 24,
  parameter int ADDR_W = 8,
  parameter int LEN_W  = 9
);
  logic              start;
  logic [LEN_W-1:0]  len;
  logic [ADDR_W-1:0] act_base;
  logic [ADDR_W-1:0] w_base;
  logic              busy;
  logic              done;
  logic [ACC_W-1:0]  result;
  logic              rd_en;
  logic [ADDR_W-1:0] act_addr;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] act_data;
  logic [DATA_W-1:0] w_data;
  logic              mac_rst;
  logic [DATA_W-1:0] mac_a;
  logic [DATA_W-1:0] mac_b;
  logic [ACC_W-1:0]  mac_out;

  modport slave (
    input  start, len, act_base, w_base,
    input  act_data, w_data, mac_out,
    output busy, done, result,
    output rd_en, act_addr, w_addr,
    output mac_rst, mac_a, mac_b
  );

  modport master (
    output start, len, act_base, w_base,
    output act_data, w_data, mac_out,
    input  busy, done, result,
    input  rd_en, act_addr, w_addr,
    input  mac_rst, mac_a, mac_b
  );
endinterface

// File: rtl/mac_seq_ctrl.sv
// MAC job sequencer: clears the MAC, streams len operand pairs, captures result.
// Ports: clk, reset (sync, active-high), bus (mac_seq_ctrl_if.slave).
module mac_seq_ctrl #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 24,
  parameter int ADDR_W = 8,
  parameter int LEN_W  = 9
) (
  input logic           clk,
  input logic           reset,
  mac_seq_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [LEN_W-1:0]  k_q, k_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [ADDR_W-1:0] ab_q, ab_d;
  logic [ADDR_W-1:0] wb_q, wb_d;
  logic [ACC_W-1:0]  res_q, res_d;
  logic              done_q, done_d;
  logic              vld_q;
  logic              rd_en;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      len_q   <= '0;
      ab_q    <= '0;
      wb_q    <= '0;
      res_q   <= '0;
      done_q  <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      len_q   <= len_d;
      ab_q    <= ab_d;
      wb_q    <= wb_d;
      res_q   <= res_d;
      done_q  <= done_d;
      vld_q   <= rd_en;
    end
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    len_d   = len_q;
    ab_d    = ab_q;
    wb_d    = wb_q;
    res_d   = res_q;
    done_d  = 1'b0;
    rd_en   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          if (bus.len != '0) begin
            len_d   = bus.len;
            ab_d    = bus.act_base;
            wb_d    = bus.w_base;
            k_d     = '0;
            state_d = S_CLEAR;
          end else begin
            // Empty job completes at once with a zero sum.
            done_d = 1'b1;
            res_d  = '0;
          end
        end
      end
      S_CLEAR: begin
        rd_en   = 1'b1;
        k_d     = LEN_W'(1);
        state_d = (len_q > LEN_W'(1)) ? S_RUN : S_DRAIN;
      end
      S_RUN: begin
        rd_en = 1'b1;
        k_d   = k_q + LEN_W'(1);
        if (k_q == len_q - LEN_W'(1)) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        state_d = S_DONE;
      end
      S_DONE: begin
        res_d   = bus.mac_out;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // k is 0 in CLEAR, so the index is simply the low bits of k.
  assign bus.act_addr = ab_q + k_q[ADDR_W-1:0];
  assign bus.w_addr   = wb_q + k_q[ADDR_W-1:0];
  assign bus.rd_en    = rd_en;
  assign bus.busy     = (state_q != S_IDLE);
  assign bus.done     = done_q;
  assign bus.result   = res_q;
  assign bus.mac_rst  = reset | (state_q == S_CLEAR);

  // Read data is valid one cycle after the strobe; feed zeros otherwise.
  assign bus.mac_a = vld_q ? bus.act_data : {DATA_W{1'b0}};
  assign bus.mac_b = vld_q ? bus.w_data : {DATA_W{1'b0}};

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Directed bench for mac_seq_ctrl with buffer and 8x8->24 MAC models.
// Checks timing, addressing, gating, result values, reset abort.
module tb_mac_seq_ctrl;

  logic clk;
  logic reset;

  mac_seq_ctrl_if #(8, 24, 8, 9) bus ();

  mac_seq_ctrl #(
    .DATA_W(8),
    .ACC_W (24),
    .ADDR_W(8),
    .LEN_W (9)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  logic [7:0] act_mem [256];
  logic [7:0] w_mem   [256];

  int errors;
  int checks;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.rd_en) begin
      bus.act_data <= act_mem[bus.act_addr];
      bus.w_data   <= w_mem[bus.w_addr];
    end
  end

  always @(posedge clk) begin
    if (bus.mac_rst)
      bus.mac_out <= '0;
    else
      bus.mac_out <= bus.mac_out +
        ({16'd0, bus.mac_a} * {16'd0, bus.mac_b});
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Called in cycle 0 (start driven here); returns in the done cycle.
  task automatic run_job(input string tag,
                         input int l,
                         input logic [7:0] ab,
                         input logic [7:0] wb,
                         input logic [23:0] exp,
                         input int inj);
    int bad_busy;
    int bad_rd;
    int bad_addr;
    int bad_gate;
    int bad_rst;
    int done_cyc;
    int done_cnt;
    logic [7:0] ea;
    logic [7:0] ew;
    bad_busy = 0;
    bad_rd   = 0;
    bad_addr = 0;
    bad_gate = 0;
    bad_rst  = 0;
    done_cyc = -1;
    done_cnt = 0;
    bus.start    = 1'b1;
    bus.len      = 9'(l);
    bus.act_base = ab;
    bus.w_base   = wb;
    chk({tag, "_busy0"}, 32'(bus.busy), 32'd0);
    tick();
    bus.start = 1'b0;
    for (int c = 1; c <= l + 3; c++) begin
      if (bus.busy !== (c <= l + 2)) bad_busy++;
      if (bus.rd_en !== (c <= l)) bad_rd++;
      if (bus.mac_rst !== (c == 1)) bad_rst++;
      if (bus.rd_en === 1'b1) begin
        ea = ab + 8'(c - 1);
        ew = wb + 8'(c - 1);
        if (bus.act_addr !== ea || bus.w_addr !== ew)
          bad_addr++;
      end
      if (c == 1 || c >= l + 2) begin
        if (bus.mac_a !== 8'd0 || bus.mac_b !== 8'd0)
          bad_gate++;
      end
      if (bus.done === 1'b1) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (c == l + 3)
        chk({tag, "_result"}, 32'(bus.result), 32'(exp));
      if (c < l + 3) begin
        bus.start = (c == inj);
        if (c == inj) bus.len = 9'd9;
        tick();
        bus.start = 1'b0;
      end
    end
    chk({tag, "_done_cyc"}, 32'(done_cyc), 32'(l + 3));
    chk({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
    chk({tag, "_busy"}, 32'(bad_busy), 32'd0);
    chk({tag, "_rd_en"}, 32'(bad_rd), 32'd0);
    chk({tag, "_addr"}, 32'(bad_addr), 32'd0);
    chk({tag, "_gate"}, 32'(bad_gate), 32'd0);
    chk({tag, "_mac_rst"}, 32'(bad_rst), 32'd0);
  endtask

  initial begin
    int dcnt;
    errors = 0;
    checks = 0;
    for (int i = 0; i < 256; i++) begin
      act_mem[i] = 8'd0;
      w_mem[i]   = 8'd0;
    end
    reset        = 1'b1;
    bus.start    = 1'b0;
    bus.len      = '0;
    bus.act_base = '0;
    bus.w_base   = '0;
    tick();
    tick();
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_result", 32'(bus.result), 32'd0);
    chk("rst_rd_en", 32'(bus.rd_en), 32'd0);
    chk("rst_mac_rst", 32'(bus.mac_rst), 32'd1);
    chk("rst_mac_a", 32'(bus.mac_a), 32'd0);
    reset = 1'b0;
    tick();
    chk("idle_mac_rst", 32'(bus.mac_rst), 32'd0);

    act_mem[0] = 8'd3;
    w_mem[0]   = 8'd4;
    run_job("len1", 1, 8'h00, 8'h00, 24'd12, 0);
    tick();
    chk("len1_done_off", 32'(bus.done), 32'd0);
    tick();

    act_mem[0] = 8'd15;  w_mem[0] = 8'd10;
    act_mem[1] = 8'd25;  w_mem[1] = 8'd20;
    act_mem[2] = 8'd50;  w_mem[2] = 8'd30;
    act_mem[3] = 8'd100; w_mem[3] = 8'd50;
    act_mem[16] = 8'd2;  w_mem[16] = 8'd3;
    act_mem[17] = 8'd4;  w_mem[17] = 8'd5;
    run_job("len4", 4, 8'h00, 8'h00, 24'd7150, 0);
    run_job("b2b", 2, 8'h10, 8'h10, 24'd26, 0);
    tick();
    tick();

    act_mem[32] = 8'd1; w_mem[32] = 8'd2;
    act_mem[33] = 8'd3; w_mem[33] = 8'd4;
    act_mem[34] = 8'd5; w_mem[34] = 8'd6;
    act_mem[35] = 8'd7; w_mem[35] = 8'd8;
    run_job("ign", 4, 8'h20, 8'h20, 24'd100, 3);
    tick();
    chk("ign_idle", 32'(bus.busy), 32'd0);
    tick();

    act_mem[254] = 8'd1; w_mem[254] = 8'd10;
    act_mem[255] = 8'd2; w_mem[255] = 8'd20;
    act_mem[0]   = 8'd3; w_mem[0]   = 8'd30;
    act_mem[1]   = 8'd4; w_mem[1]   = 8'd40;
    run_job("wrap", 4, 8'hFE, 8'hFE, 24'd300, 0);
    tick();
    tick();

    for (int i = 0; i < 256; i++) begin
      act_mem[i] = 8'd255;
      w_mem[i]   = 8'd255;
    end
    run_job("len256", 256, 8'h00, 8'h00, 24'd16646400, 0);
    tick();
    tick();

    bus.start = 1'b1;
    bus.len   = 9'd0;
    tick();
    bus.start = 1'b0;
    chk("len0_done", 32'(bus.done), 32'd1);
    chk("len0_result", 32'(bus.result), 32'd0);
    chk("len0_busy", 32'(bus.busy), 32'd0);
    chk("len0_rd_en", 32'(bus.rd_en), 32'd0);
    tick();
    chk("len0_done_off", 32'(bus.done), 32'd0);
    chk("len0_rd_en2", 32'(bus.rd_en), 32'd0);

    for (int i = 0; i < 8; i++) begin
      act_mem[64 + i] = 8'(i + 1);
      w_mem[64 + i]   = 8'd1;
    end
    run_job("pre", 1, 8'h40, 8'h40, 24'd1, 0);
    tick();
    bus.start    = 1'b1;
    bus.len      = 9'd8;
    bus.act_base = 8'h40;
    bus.w_base   = 8'h40;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    tick();
    chk("abort_in_run", 32'(bus.rd_en), 32'd1);
    reset = 1'b1;
    #1;
    chk("abort_mac_rst", 32'(bus.mac_rst), 32'd1);
    tick();
    reset = 1'b0;
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_result", 32'(bus.result), 32'd0);
    chk("abort_done", 32'(bus.done), 32'd0);
    dcnt = 0;
    for (int c = 0; c < 12; c++) begin
      if (bus.done === 1'b1 || bus.busy === 1'b1) dcnt++;
      tick();
    end
    chk("abort_quiet", 32'(dcnt), 32'd0);

    act_mem[80] = 8'd7;
    w_mem[80]   = 8'd6;
    run_job("fresh", 1, 8'h50, 8'h50, 24'd42, 0);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
